// File: rtl/fifo_level_ctrl_if.sv
// Handshake and status bundle between a FIFO datapath and its pointer/flag controller.
// The master drives the requests. The slave (the controller) drives the accept strobes, pointers, level and flags.
interface fifo_level_ctrl_if #(
  parameter int ADDR_WIDTH = 8
);
  logic                  flush;
  logic                  wr;
  logic                  rd;
  logic                  err_clr;
  logic                  wr_acc;
  logic                  rd_acc;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH:0]   level;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output flush, wr, rd, err_clr,
    input  wr_acc, rd_acc, w_addr, r_addr, level,
    input  full, empty, almost_full, almost_empty, overflow, underflow
  );

  modport slave (
    input  flush, wr, rd, err_clr,
    output wr_acc, rd_acc, w_addr, r_addr, level,
    output full, empty, almost_full, almost_empty, overflow, underflow
  );
endinterface

// File: rtl/fifo_level_ctrl.sv
// FIFO pointer/flag controller for a 2**ADDR_WIDTH-entry register file.
// It keeps an occupancy count, threshold flags, sticky overflow/underflow errors and a synchronous flush.
module fifo_level_ctrl #(
  parameter int ADDR_WIDTH = 8,
  parameter int AF_TH      = (2 ** ADDR_WIDTH) - 2,
  parameter int AE_TH      = 1
) (
  input logic              clk,
  input logic              reset,
  fifo_level_ctrl_if.slave bus
);
  localparam int                DEPTH   = 2 ** ADDR_WIDTH;
  localparam int                LVL_W   = ADDR_WIDTH + 1;
  localparam logic [LVL_W-1:0]  DEPTH_L = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0]  AF_L    = LVL_W'(AF_TH);
  localparam logic [LVL_W-1:0]  AE_L    = LVL_W'(AE_TH);

  generate
    if (AF_TH < 1 || AF_TH > DEPTH) begin : g_af_range
      $error("fifo_level_ctrl: AF_TH=%0d outside 1..%0d", AF_TH, DEPTH);
    end
    if (AE_TH < 0 || AE_TH > DEPTH - 1) begin : g_ae_range
      $error("fifo_level_ctrl: AE_TH=%0d outside 0..%0d", AE_TH, DEPTH - 1);
    end
  endgenerate

  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic [LVL_W-1:0]      w_level_next;
  logic                  w_ovf_next;
  logic                  w_udf_next;

  logic [ADDR_WIDTH-1:0] r_wptr;
  logic [ADDR_WIDTH-1:0] r_rptr;
  logic [LVL_W-1:0]      r_level;
  logic                  r_full;
  logic                  r_empty;
  logic                  r_afull;
  logic                  r_aempty;
  logic                  r_ovf;
  logic                  r_udf;

  // A read on a full FIFO frees the slot, so the paired write is also accepted.
  assign w_rd_acc = bus.rd & ~r_empty & ~bus.flush;
  assign w_wr_acc = bus.wr & (~r_full | bus.rd) & ~bus.flush;

  assign w_level_next = r_level + LVL_W'(w_wr_acc) - LVL_W'(w_rd_acc);

  // A new error in the same cycle as err_clr takes priority over the clear.
  assign w_ovf_next = (r_ovf & ~bus.err_clr) | (bus.wr & ~w_wr_acc & ~bus.flush);
  assign w_udf_next = (r_udf & ~bus.err_clr) | (bus.rd & ~w_rd_acc & ~bus.flush);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_level  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_afull  <= 1'b0;
      r_aempty <= 1'b1;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else begin
      r_ovf <= w_ovf_next;
      r_udf <= w_udf_next;
      if (bus.flush) begin
        r_wptr   <= '0;
        r_rptr   <= '0;
        r_level  <= '0;
        r_full   <= 1'b0;
        r_empty  <= 1'b1;
        r_afull  <= 1'b0;
        r_aempty <= 1'b1;
      end else begin
        r_wptr   <= r_wptr + ADDR_WIDTH'(w_wr_acc);
        r_rptr   <= r_rptr + ADDR_WIDTH'(w_rd_acc);
        r_level  <= w_level_next;
        r_full   <= (w_level_next == DEPTH_L);
        r_empty  <= (w_level_next == '0);
        r_afull  <= (w_level_next >= AF_L);
        r_aempty <= (w_level_next <= AE_L);
      end
    end
  end

  assign bus.wr_acc       = w_wr_acc;
  assign bus.rd_acc       = w_rd_acc;
  assign bus.w_addr       = r_wptr;
  assign bus.r_addr       = r_rptr;
  assign bus.level        = r_level;
  assign bus.full         = r_full;
  assign bus.empty        = r_empty;
  assign bus.almost_full  = r_afull;
  assign bus.almost_empty = r_aempty;
  assign bus.overflow     = r_ovf;
  assign bus.underflow    = r_udf;
endmodule
